shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Round-robin write arbiter for a shared DATA_W-bit register built from D flip-flops. Up to N_REQ requesters present write or clear requests over a valid/ready handshake, and the block grants one per cycle. The granted value is loaded into the shared register, and the block reports the current value, the last writer and a written-since-reset flag. It sits between the control agents and any status or configuration register they contend for.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16
- DATA_W, 8: shared register width
- MAX_LOCK, 15: LOCK-state idle timeout in cycles (used only with lock feature)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester request
- req_data  in  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
- req_clear  in  N_REQ  request is a clear; data ignored
- req_lock  in  N_REQ  keep grant after this transfer (lock feature only)
- req_ready  out  N_REQ  registered one-hot grant; transfer when req_valid[i] & req_ready[i]
- q  out  DATA_W  shared register value
- q_owner  out  $clog2(N_REQ)  index of last successful writer
- q_valid  out  1  register written or cleared at least once since reset
- busy  out  1  state != IDLE

## Operation
- Reset values: q=0, q_owner=0, q_valid=0, req_ready=0, busy=0, rr pointer=0, state IDLE.
- Reset asserted mid-operation aborts the pending grant immediately and performs no write.
- IDLE: if any req_valid, pick g = first valid index at or after pointer (wrapping), latch it, and go to GRANT. Otherwise stay.
- GRANT: req_ready = onehot(g).
  - Transfer (req_valid[g]=1): next edge sets q = req_clear[g] ? 0 : data[g], q_owner = g, q_valid = 1, pointer = (g+1) mod N_REQ.
  - Transfer, then next state: re-arbitrate from the new pointer over the current req_valid with g excluded. If a winner exists, stay in GRANT with the new g. If none exist, go to IDLE.
  - No transfer (g withdrew): no write, pointer unchanged. Re-arbitrate over the current req_valid, staying in GRANT with the new g, or go to IDLE if no requester is valid.
- Sustained throughput: one write per cycle when ≥2 requesters are continuously valid. A single requester that stays valid gets a transfer every other cycle, because it passes back through IDLE.
- Fairness: each continuously-valid requester is granted within N_REQ transfers.
- Pointer wrap: when g = N_REQ-1, the pointer becomes 0.

## Timing
- First grant latency: req_valid rises in cycle 0 (IDLE) → req_ready in cycle 1.
- Write latency: transfer in cycle n → q, q_owner and q_valid update in cycle n+1.
- req_ready is registered and never depends combinationally on req_valid in the same cycle.
- Requesters may drop req_valid at any time. A grant without a matching valid is simply lost.

## Configuration
- SHARED_REG_ARB_LOCK_EN defined:
  - A transfer with req_lock[g]=1 enters LOCK, where req_ready stays onehot(g) and other requesters are ignored.
  - A transfer with req_lock[g]=0 leaves LOCK and re-arbitrates as in GRANT.
  - MAX_LOCK consecutive cycles without a transfer forces release: pointer = (g+1) mod N_REQ, then go to IDLE.
- Not defined: req_lock is ignored, there is no LOCK state, and MAX_LOCK is unused.

## Structure
- Package shared_reg_arb_pkg holds the state enum (IDLE, GRANT, LOCK) and a function for the index width.
- One sub-module, rr_pick: combinational round-robin select taking the valid vector, pointer and exclude mask, and returning found and index.

## Test plan
- Reset: hold rst, drive all valid → all outputs 0. Release → req_ready=0001 one cycle after the first clock edge.
- Single writer: req 2 valid with data 0xA5 → ready[2] in cycle 1, q=0xA5, q_owner=2, q_valid=1 in cycle 2.
- Contention: all 4 valid continuously with data 0x10..0x13 → grant order 0,1,2,3,0 with one write per cycle, q following 0x10,0x11,0x12,0x13.
- Clear and withdraw: req 1 transfers with clear and data 0xFF → q=0x00. Req 3 drops valid while granted → no write, q and q_owner unchanged.
- Async reset mid-grant: assert rst during GRANT → req_ready clears immediately, q stays 0, no write.
- LOCK_EN: req 0 holds lock for 3 transfers while req 1 is valid → req 1 is ready only after the unlocked transfer. With req 0 idle in LOCK for 15 cycles → forced release and req 1 is granted next.

Source files
------------

// File: rtl/shared_reg_arb_pkg.sv
// Shared types for the shared-register round-robin write arbiter.
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin select: first valid, non-excluded index at or after ptr_i.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Scan from the far end so the last hit is the one nearest the pointer.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j] && !excl_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of a shared DATA_W-bit register.
// Optional grant locking with idle timeout is built when SHARED_REG_ARB_LOCK_EN is defined.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_clear,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          q,
  output logic [$clog2(N_REQ)-1:0]   q_owner,
  output logic                       q_valid,
  output logic                       busy
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e        state_q;
  logic [IW-1:0]     g_q, ptr_q, ptr_inc;
  logic [N_REQ-1:0]  ready_q;
  logic [DATA_W-1:0] q_q;
  logic [IW-1:0]     owner_q;
  logic              qv_q;

  logic              xfer;
  logic [IW-1:0]     pick_ptr_d, pick_idx;
  logic [N_REQ-1:0]  pick_excl_d, pick_oh;
  logic              pick_found;

  // After a transfer the winner is excluded and the search restarts past it.
  always_comb begin
    xfer        = (state_q != IDLE) && req_valid[g_q];
    ptr_inc     = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
    pick_ptr_d  = xfer ? ptr_inc : ptr_q;
    pick_excl_d = '0;
    pick_excl_d[g_q] = xfer;
    pick_oh     = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (pick_ptr_d),
    .excl_i  (pick_excl_d),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef SHARED_REG_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt_q;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock ^ (MAX_LOCK != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      ready_q <= '0;
      q_q     <= '0;
      owner_q <= '0;
      qv_q    <= 1'b0;
`ifdef SHARED_REG_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      if (xfer) begin
        q_q     <= req_clear[g_q] ? '0 : req_data[g_q*DATA_W +: DATA_W];
        owner_q <= g_q;
        qv_q    <= 1'b1;
        ptr_q   <= ptr_inc;
      end
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            g_q     <= pick_idx;
            ready_q <= pick_oh;
            state_q <= GRANT;
          end
        end
        default: begin
`ifdef SHARED_REG_ARB_LOCK_EN
          if (xfer && req_lock[g_q]) begin
            state_q    <= LOCK;
            lock_cnt_q <= '0;
          end else if (!xfer && state_q == LOCK) begin
            // Idle owner: release after MAX_LOCK quiet cycles, skipping past it.
            if (lock_cnt_q == CW'(MAX_LOCK - 1)) begin
              ptr_q   <= ptr_inc;
              ready_q <= '0;
              state_q <= IDLE;
            end else begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end else
`endif
          if (pick_found) begin
            g_q     <= pick_idx;
            ready_q <= pick_oh;
            state_q <= GRANT;
          end else begin
            ready_q <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign q         = q_q;
  assign q_owner   = owner_q;
  assign q_valid   = qv_q;
  assign busy      = (state_q != IDLE);

endmodule
